// File: rtl/timer_pkg.sv
// timer_pkg: register map offsets, CTRL bit positions and the per-channel
// register selector shared by mmio_timer_n and timer_channel.
package timer_pkg;

  // Byte offsets inside the timer window, relative to BASE_ADDR
  localparam logic [7:0] OFF_COUNT    = 8'h00;
  localparam logic [7:0] OFF_PENDING  = 8'h04;
  localparam logic [7:0] OFF_MASK     = 8'h08;
  localparam logic [7:0] OFF_PRESCALE = 8'h0C;
  localparam logic [7:0] OFF_CH_BASE  = 8'h10;
  localparam logic [7:0] CH_STRIDE    = 8'h10;

  // Bit positions inside a channel CTRL register
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;

  // Word slot inside one channel's 16-byte block
  typedef enum logic [1:0] {
    CH_COMPARE = 2'd0,
    CH_PERIOD  = 2'd1,
    CH_CTRL    = 2'd2,
    CH_RSVD    = 2'd3
  } chReg_e;

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one compare channel (COMPARE, PERIOD, CTRL) with its match
// detection, periodic reload / one-shot disable, and register read data.
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_wrEn,
  input  logic [1:0]       i_regSel,
  input  logic [WIDTH-1:0] i_wrData,
  output logic             o_match,
  output logic [31:0]      o_rdData
);

  logic [WIDTH-1:0] r_compare;
  logic [WIDTH-1:0] r_period;
  logic [1:0]       r_ctrl;
  chReg_e           w_reg;

  assign w_reg   = chReg_e'(i_regSel);
  assign o_match = i_tick & r_ctrl[CTRL_EN] & (i_count == r_compare);

  // Match side effects first, then any software write so the write wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_compare <= '0;
      r_period  <= '0;
      r_ctrl    <= '0;
    end else begin
      if (o_match) begin
        if (r_ctrl[CTRL_PERIODIC]) r_compare <= r_compare + r_period;
        else                       r_ctrl[CTRL_EN] <= 1'b0;
      end
      if (i_wrEn) begin
        case (w_reg)
          CH_COMPARE: r_compare <= i_wrData;
          CH_PERIOD:  r_period  <= i_wrData;
          CH_CTRL:    r_ctrl    <= i_wrData[1:0];
          default:    ;
        endcase
      end
    end
  end

  // Register read data, zero-extended; the reserved slot reads 0
  always_comb begin
    o_rdData = '0;
    case (w_reg)
      CH_COMPARE: o_rdData = 32'(r_compare);
      CH_PERIOD:  o_rdData = 32'(r_period);
      CH_CTRL:    o_rdData = 32'(r_ctrl);
      default:    o_rdData = '0;
    endcase
  end

endmodule

// File: rtl/mmio_timer_n.sv
// mmio_timer_n: NUM_CH-channel memory-mapped interrupt timer sharing one
// free-running counter. Holds COUNT, PENDING, MASK, the prescaler, address
// decode and read mux. Optional macro TIMER_PRESCALE_EN enables PRESCALE.
module mmio_timer_n
  import timer_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hffff0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        TimerInterrupt,
  output logic [31:0] cycle,
  output logic        TimerAddress,
  input  logic [31:0] data,
  input  logic [31:0] address,
  input  logic        MemRead,
  input  logic        MemWrite
);

  localparam logic [31:0] LAST_OFF = 32'h0F + 32'(16 * NUM_CH);

  logic [WIDTH-1:0]  r_count;
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_mask;

  logic [31:0]       w_offset;
  logic [7:0]        w_regOff;
  logic [7:0]        w_chOff;
  logic [3:0]        w_chIdx;
  logic [1:0]        w_chReg;
  logic              w_isGlobal;
  logic              w_wrEn;
  logic              w_wrCount;
  logic              w_wrPending;
  logic              w_wrMask;
  logic              w_wrPrescale;
  logic [WIDTH-1:0]  w_wrData;
  logic              w_tick;
  logic [31:0]       w_prescaleRd;
  logic [NUM_CH-1:0] w_match;
  logic [31:0]       w_chRd [NUM_CH];
  logic [31:0]       w_rdData;
  logic              w_unused;

  // Address decode; the low two address bits are ignored
  assign w_offset     = address - BASE_ADDR;
  assign TimerAddress = (address >= BASE_ADDR) && (w_offset <= LAST_OFF);
  assign w_regOff     = {w_offset[7:2], 2'b00};
  assign w_isGlobal   = (w_regOff < OFF_CH_BASE);
  assign w_chOff      = w_regOff - OFF_CH_BASE;
  assign w_chIdx      = 4'(w_chOff / CH_STRIDE);
  assign w_chReg      = 2'((w_chOff % CH_STRIDE) >> 2);

  assign w_wrEn       = MemWrite & TimerAddress;
  assign w_wrData     = data[WIDTH-1:0];
  assign w_wrCount    = w_wrEn & w_isGlobal & (w_regOff == OFF_COUNT);
  assign w_wrPending  = w_wrEn & w_isGlobal & (w_regOff == OFF_PENDING);
  assign w_wrMask     = w_wrEn & w_isGlobal & (w_regOff == OFF_MASK);
  assign w_wrPrescale = w_wrEn & w_isGlobal & (w_regOff == OFF_PRESCALE);

`ifdef TIMER_PRESCALE_EN
  logic [WIDTH-1:0] r_prescale;
  logic [WIDTH-1:0] r_psCnt;

  assign w_tick       = (r_psCnt == r_prescale);
  assign w_prescaleRd = 32'(r_prescale);
  // Reads are side-effect free, so the load strobe carries no information here
  assign w_unused     = &{1'b0, MemRead, data};

  // Prescale ticker: tick every PRESCALE+1 cycles, restarted by a PRESCALE write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescale <= '0;
      r_psCnt    <= '0;
    end else if (w_wrPrescale) begin
      r_prescale <= w_wrData;
      r_psCnt    <= '0;
    end else if (w_tick) begin
      r_psCnt    <= '0;
    end else begin
      r_psCnt    <= r_psCnt + WIDTH'(1);
    end
  end
`else
  assign w_tick       = 1'b1;
  assign w_prescaleRd = '0;
  // PRESCALE writes are dropped and reads carry no side effects
  assign w_unused     = &{1'b0, MemRead, w_wrPrescale, data};
`endif

  // One compare channel per slot, each decoding its own 16-byte block
  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .i_tick   (w_tick),
      .i_count  (r_count),
      .i_wrEn   (w_wrEn & ~w_isGlobal & (w_chIdx == 4'(g))),
      .i_regSel (w_chReg),
      .i_wrData (w_wrData),
      .o_match  (w_match[g]),
      .o_rdData (w_chRd[g])
    );
  end

  // Free-running counter; a software load overrides that cycle's increment
  always_ff @(posedge clk) begin
    if (reset)          r_count <= '0;
    else if (w_wrCount) r_count <= w_wrData;
    else if (w_tick)    r_count <= r_count + WIDTH'(1);
  end

  // Pending bits: write-1-clear, but a match on the same edge keeps the bit set
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_mask    <= '0;
    end else begin
      r_pending <= (r_pending & ~(w_wrPending ? data[NUM_CH-1:0] : '0)) | w_match;
      if (w_wrMask) r_mask <= data[NUM_CH-1:0];
    end
  end

  assign TimerInterrupt = |(r_pending & r_mask);

  // Combinational read mux; anything not addressed or unmapped reads 0
  always_comb begin
    w_rdData = '0;
    if (TimerAddress) begin
      if (w_isGlobal) begin
        case (w_regOff)
          OFF_COUNT:    w_rdData = 32'(r_count);
          OFF_PENDING:  w_rdData = 32'(r_pending);
          OFF_MASK:     w_rdData = 32'(r_mask);
          OFF_PRESCALE: w_rdData = w_prescaleRd;
          default:      w_rdData = '0;
        endcase
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (w_chIdx == 4'(i)) w_rdData = w_chRd[i];
        end
      end
    end
  end

  assign cycle = w_rdData;

endmodule

// File: tb/tb_mmio_timer_n.sv
// tb_mmio_timer_n: drives directed and random bus traffic into mmio_timer_n,
// predicts every cycle's TimerAddress / TimerInterrupt / load data from a
// behavioural register-map model, and checks them through a scoreboard queue.
module tb_mmio_timer_n;

  localparam int          NCH  = 3;
  localparam int          W    = 8;
  localparam logic [31:0] BASE = 32'hffff0100;
  localparam int unsigned M    = 1 << W;

  logic        clk;
  logic        reset;
  logic        TimerInterrupt;
  logic [31:0] cycle;
  logic        TimerAddress;
  logic [31:0] data;
  logic [31:0] address;
  logic        MemRead;
  logic        MemWrite;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        hit;
    logic        irq;
    logic        rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t expQ[$];

  // Behavioural model state
  int unsigned mCount, mPre, mSince;
  bit [NCH-1:0] mPend, mMask;
  int unsigned mCmp[NCH], mPer[NCH];
  bit mEn[NCH], mPerd[NCH];
  int cyc = 0;

  mmio_timer_n #(.NUM_CH(NCH), .WIDTH(W), .BASE_ADDR(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .TimerInterrupt (TimerInterrupt),
    .cycle          (cycle),
    .TimerAddress   (TimerAddress),
    .data           (data),
    .address        (address),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit mInWin(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a >= BASE) && (off <= 32'h0F + 32'(16 * NCH));
  endfunction

  function automatic logic [31:0] mRead(input logic [31:0] a);
    int unsigned off, ch;
    logic [31:0] diff;
    if (!mInWin(a)) return 32'h0;
    diff = (a - BASE) & 32'hFFFF_FFFC;
    off  = diff;
    if (off < 16) begin
      case (off)
        0:  return mCount;
        4:  return 32'(mPend);
        8:  return 32'(mMask);
`ifdef TIMER_PRESCALE_EN
        12: return mPre;
`endif
        default: return 32'h0;
      endcase
    end
    ch = (off - 16) / 16;
    case (off % 16)
      0:  return mCmp[ch];
      4:  return mPer[ch];
      8:  return 32'(mEn[ch]) + 32'(2 * mPerd[ch]);
      default: return 32'h0;
    endcase
  endfunction

  task automatic modelReset();
    mCount = 0; mPre = 0; mSince = 0; mPend = '0; mMask = '0;
    for (int c = 0; c < NCH; c++) begin
      mCmp[c] = 0; mPer[c] = 0; mEn[c] = 0; mPerd[c] = 0;
    end
  endtask

  task automatic modelEdge(input bit rst, input bit wr, input logic [31:0] a, input logic [31:0] d);
    bit tick;
    bit [NCH-1:0] hit;
    int unsigned dv, off, ch, nextCount;
    logic [31:0] diff;
    if (rst) begin
      modelReset();
      return;
    end
`ifdef TIMER_PRESCALE_EN
    tick = ((mSince % (mPre + 1)) == mPre);
`else
    tick = 1'b1;
`endif
    hit = '0;
    for (int c = 0; c < NCH; c++)
      if (tick && mEn[c] && mCount == mCmp[c]) hit[c] = 1'b1;
    nextCount = tick ? (mCount + 1) % M : mCount;
    mSince++;
    for (int c = 0; c < NCH; c++) begin
      if (hit[c]) begin
        if (mPerd[c]) mCmp[c] = (mCmp[c] + mPer[c]) % M;
        else          mEn[c] = 1'b0;
      end
    end
    if (wr && mInWin(a)) begin
      dv   = d % M;
      diff = (a - BASE) & 32'hFFFF_FFFC;
      off  = diff;
      if (off < 16) begin
        case (off)
          0:  nextCount = dv;
          4:  mPend = mPend & ~d[NCH-1:0];
          8:  mMask = d[NCH-1:0];
          12: begin
`ifdef TIMER_PRESCALE_EN
            mPre = dv;
            mSince = 0;
`endif
          end
          default: ;
        endcase
      end else begin
        ch = (off - 16) / 16;
        case (off % 16)
          0: mCmp[ch] = dv;
          4: mPer[ch] = dv;
          8: begin mEn[ch] = d[0]; mPerd[ch] = d[1]; end
          default: ;
        endcase
      end
    end
    mPend = mPend | hit;
    mCount = nextCount;
  endtask

  // One bus cycle: drive inputs, queue the expected response, advance the model at the edge
  task automatic applyStimulus(input bit rst, input bit wr, input bit rd,
                               input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    reset = rst; MemWrite = wr; MemRead = rd; address = a; data = d;
    e.name  = $sformatf("c%0d_off%0h", cyc, a - BASE);
    e.hit   = mInWin(a);
    e.irq   = |(mPend & mMask);
    e.rd    = rd;
    e.rdata = mRead(a);
    expQ.push_back(e);
    cyc++;
    @(posedge clk);
    modelEdge(rst, wr, a, d);
    #1;
  endtask

  task automatic wrReg(input logic [7:0] off, input logic [31:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, BASE + 32'(off), d);
  endtask

  task automatic rdReg(input logic [7:0] off);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'(off), 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Advance with PENDING reads until the model counter reaches target
  task automatic runUntil(input int unsigned target);
    int guard = 0;
    while (mCount != target && guard < 600) begin
      rdReg(8'h04);
      guard++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: one scoreboard entry per driven cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput({e.name, "_addr"}, 32'(TimerAddress), 32'(e.hit));
      checkOutput({e.name, "_irq"}, 32'(TimerInterrupt), 32'(e.irq));
      if (e.rd) checkOutput({e.name, "_data"}, cycle, e.rdata);
    end
  end

  initial begin
    int r;
    logic [31:0] a, d;
    reset = 1'b1; MemWrite = 1'b0; MemRead = 1'b0; address = 32'h0; data = 32'h0;
    modelReset();
    @(posedge clk);
    #1;

    // Reset, idle, then read the whole map including just outside both ends
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(10);
    rdReg(8'h00);
    for (int o = 4; o <= 8'h40; o += 4) rdReg(8'(o));
    applyStimulus(1'b0, 1'b0, 1'b1, BASE - 32'd4, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, BASE + 32'h3F, 32'h0);

    // One-shot on channel 0
    wrReg(8'h00, 32'h0); wrReg(8'h10, 32'd20); wrReg(8'h18, 32'h1); wrReg(8'h08, 32'h1);
    for (int i = 0; i < 22; i++) rdReg(8'h04);
    rdReg(8'h18);
    wrReg(8'h04, 32'h1);
    rdReg(8'h04);

    // Periodic channel 2 with write-1-clear after each hit
    wrReg(8'h00, 32'h0); wrReg(8'h30, 32'd5); wrReg(8'h34, 32'd7); wrReg(8'h38, 32'h3);
    wrReg(8'h08, 32'h4);
    for (int i = 0; i < 26; i++) begin
      if (mPend[2]) wrReg(8'h04, 32'h4);
      else          rdReg(8'h04);
    end
    wrReg(8'h38, 32'h0); wrReg(8'h04, 32'h7);

    // Clear on the same edge as a channel 1 match: set wins
    wrReg(8'h08, 32'h2); wrReg(8'h00, 32'h0); wrReg(8'h20, 32'd8); wrReg(8'h28, 32'h1);
    runUntil(8);
    wrReg(8'h04, 32'h2);
    rdReg(8'h04); rdReg(8'h04);
    wrReg(8'h04, 32'h2); rdReg(8'h04);

    // Software CTRL write on a one-shot match edge keeps EN
    wrReg(8'h00, 32'h0); wrReg(8'h10, 32'd6); wrReg(8'h18, 32'h1);
    runUntil(6);
    wrReg(8'h18, 32'h1);
    rdReg(8'h18); rdReg(8'h04);
    // Software COMPARE write on a periodic match edge beats the reload
    wrReg(8'h18, 32'h0); wrReg(8'h20, 32'd30); wrReg(8'h24, 32'd5); wrReg(8'h28, 32'h3);
    runUntil(30);
    wrReg(8'h20, 32'd70);
    rdReg(8'h20); rdReg(8'h04);
    wrReg(8'h28, 32'h0); wrReg(8'h04, 32'h7);

    // Wrap: 250 then 250+10 mod 256 = 4; data bits above WIDTH dropped
    wrReg(8'h08, 32'h1); wrReg(8'h10, 32'h1234_56FA); wrReg(8'h14, 32'd10); wrReg(8'h18, 32'h3);
    wrReg(8'h00, 32'd245);
    for (int i = 0; i < 22; i++) begin
      if (mPend[0]) wrReg(8'h04, 32'h1);
      else          rdReg(8'h04);
    end
    rdReg(8'h10);
    wrReg(8'h18, 32'h0); wrReg(8'h04, 32'h7);

    // PERIOD=0 periodic: COMPARE stays put
    wrReg(8'h00, 32'h0); wrReg(8'h30, 32'd3); wrReg(8'h34, 32'h0); wrReg(8'h38, 32'h3);
    for (int i = 0; i < 6; i++) rdReg(8'h30);
    wrReg(8'h38, 32'h0); wrReg(8'h04, 32'h7);

    // PRESCALE write and readback, then watch COUNT advance
    wrReg(8'h0C, 32'd3);
    rdReg(8'h0C);
    for (int i = 0; i < 12; i++) rdReg(8'h00);
    wrReg(8'h0C, 32'h0);
    rdReg(8'h0C);

    // Reset on a match edge records nothing
    wrReg(8'h08, 32'h1); wrReg(8'h00, 32'h0); wrReg(8'h10, 32'd9); wrReg(8'h18, 32'h1);
    runUntil(9);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    rdReg(8'h04); rdReg(8'h18); rdReg(8'h00);

    // Randomized traffic around and inside the window
    for (int i = 0; i < 700; i++) begin
      r = $urandom_range(0, 99);
      a = BASE - 32'd8 + 32'($urandom_range(0, 32'h58));
      d = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) d = (mCount + $urandom_range(1, 6)) % M;
      if (r < 1)       applyStimulus(1'b1, 1'b0, 1'b0, a, d);
      else if (r < 30) applyStimulus(1'b0, 1'b1, 1'b0, a, d);
      else if (r < 80) applyStimulus(1'b0, 1'b0, 1'b1, a, d);
      else             applyStimulus(1'b0, 1'b0, 1'b0, a, d);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
